// File: rtl/board_pkg.sv
// Shared types and helpers for the playfield SDRAM sequencer.
//   cmd_op_e  : command opcodes presented on cmd_op
//   state_e   : sequencer FSM states
//   cell_addr : byte address of a board cell (wide; callers narrow to ADDR_W)
package board_pkg;

  typedef enum logic [1:0] {
    OP_MOVE     = 2'd0,
    OP_READ_ROW = 2'd1,
    OP_COPY_ROW = 2'd2,
    OP_RSVD     = 2'd3
  } cmd_op_e;

  typedef enum logic [3:0] {
    IDLE, W_LD, W_REQ, W_DRAIN, R_LD, R_WAIT, R_BURST, C_LD, C_REQ, C_DRAIN, FIN
  } state_e;

  // Two bytes per cell, row-major. Done at 64 bits so nothing is lost before
  // the shift; the low ADDR_W bits equal the result computed at ADDR_W bits.
  function automatic logic [63:0] cell_addr(input logic [63:0] x, input logic [63:0] y,
                                            input logic [63:0] board_w,
                                            input logic [63:0] base_addr);
    return base_addr + ((y * board_w + x) << 1);
  endfunction

endpackage

// File: rtl/board_sdram_seq_if.sv
// FIFO-controller side bus of the playfield sequencer.
//   master : the sequencer (drives load/push/pop strobes, addresses, write data)
//   slave  : the SDRAM FIFO controller (returns occupancies and read data)
interface board_sdram_seq_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic              write_ld;
  logic              write_req;
  logic [ADDR_W-1:0] writeaddr;
  logic [DATA_W-1:0] writedata;
  logic [15:0]       wr_buffer;
  logic              read_ld;
  logic              read_req;
  logic [ADDR_W-1:0] readaddr;
  logic [DATA_W-1:0] readdata;
  logic [15:0]       rd_buffer;

  modport master (
    output write_ld, write_req, writeaddr, writedata, read_ld, read_req, readaddr,
    input  wr_buffer, readdata, rd_buffer
  );

  modport slave (
    input  write_ld, write_req, writeaddr, writedata, read_ld, read_req, readaddr,
    output wr_buffer, readdata, rd_buffer
  );
endinterface

// File: rtl/board_cell_addr.sv
// Combinational cell-to-SDRAM byte address calculator.
//   x, y : cell coordinates
//   addr : BASE_ADDR + ((y*BOARD_W + x) << 1), ADDR_W bits
module board_cell_addr
  import board_pkg::*;
#(
  parameter int                BOARD_W   = 10,
  parameter int                COORD_W   = 7,
  parameter int                ADDR_W    = 25,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr
);
  assign addr = ADDR_W'(cell_addr(64'(x), 64'(y), 64'(BOARD_W), 64'(BASE_ADDR)));
endmodule

// File: rtl/board_sdram_seq.sv
// Playfield access sequencer between game logic and the SDRAM FIFO controller.
// Executes one command at a time: MOVE (erase old cells, paint new cells),
// READ_ROW (burst a row into row_data) or COPY_ROW (read a row, rewrite it
// elsewhere). Off-board cells are skipped; FIFO waits are bounded by TIMEOUT.
//   clk, reset            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_op, pre_*, post_*, piece_color, src_row, dst_row : command operands
//   done, err             : completion pulse, error pulse coincident with done
//   row_data              : last row read
//   fifo                  : FIFO controller bus (master side)
module board_sdram_seq
  import board_pkg::*;
#(
  parameter int                BOARD_W   = 10,
  parameter int                BOARD_H   = 20,
  parameter int                CELLS     = 4,
  parameter int                COORD_W   = 7,
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 25,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] BG_COLOR  = DATA_W'(16'h0fff),
  parameter int                TIMEOUT   = 1023
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [CELLS-1:0][COORD_W-1:0]    pre_x,
  input  logic [CELLS-1:0][COORD_W-1:0]    pre_y,
  input  logic [CELLS-1:0][COORD_W-1:0]    post_x,
  input  logic [CELLS-1:0][COORD_W-1:0]    post_y,
  input  logic [DATA_W-1:0]                piece_color,
  input  logic [COORD_W-1:0]               src_row,
  input  logic [COORD_W-1:0]               dst_row,
  output logic                             done,
  output logic                             err,
  output logic [BOARD_W-1:0][DATA_W-1:0]   row_data,
  board_sdram_seq_if.master                fifo
);
  // MOVE walks 2*CELLS cells: erase cells 0..CELLS-1, then paint cells CELLS..
  localparam int NC    = 2 * CELLS;
  localparam int IDX_W = (NC > 1) ? $clog2(NC) : 1;
  localparam int BI_W  = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [COORD_W-1:0] W_LIM       = COORD_W'(BOARD_W);
  localparam logic [COORD_W-1:0] H_LIM       = COORD_W'(BOARD_H);
  localparam logic [IDX_W-1:0]   PAINT_START = IDX_W'(CELLS);
  localparam logic [BI_W-1:0]    BI_LAST     = BI_W'(BOARD_W - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(TIMEOUT - 1);
  localparam logic [15:0]        RD_NEED     = 16'(BOARD_W);

  state_e              state, state_nxt;
  cmd_op_e             op_r;
  logic [COORD_W-1:0]  cx_r [NC];
  logic [COORD_W-1:0]  cy_r [NC];
  logic [COORD_W-1:0]  in_x [NC];
  logic [COORD_W-1:0]  in_y [NC];
  logic [DATA_W-1:0]   color_r;
  logic [COORD_W-1:0]  src_r, dst_r;
  logic [IDX_W-1:0]    idx_r, idx_nxt;
  logic [BI_W-1:0]     bi_r, bi_nxt;
  logic [TMO_W-1:0]    tmo_r, tmo_nxt;
  logic                err_r, err_nxt;
  logic                capture;

  logic [NC-1:0]       cell_ok;
  int                  start_i;
  logic                found;
  logic [IDX_W-1:0]    found_idx;
  logic [COORD_W-1:0]  ax, ay;
  logic [ADDR_W-1:0]   addr_calc;

  always_comb begin
    for (int j = 0; j < CELLS; j++) begin
      in_x[j]         = pre_x[j];
      in_y[j]         = pre_y[j];
      in_x[j + CELLS] = post_x[j];
      in_y[j + CELLS] = post_y[j];
    end
  end

  // Next on-board cell at or after start_i. In IDLE the search runs on the
  // live operands so the first W_LD follows acceptance directly; skipped
  // cells therefore cost no cycles at all.
  always_comb begin
    start_i   = (state == IDLE) ? 0 : int'(idx_r) + 1;
    found     = 1'b0;
    found_idx = '0;
    for (int j = 0; j < NC; j++) begin
      cell_ok[j] = (state == IDLE) ? (in_x[j] < W_LIM && in_y[j] < H_LIM)
                                   : (cx_r[j] < W_LIM && cy_r[j] < H_LIM);
    end
    for (int j = NC - 1; j >= 0; j--) begin
      if (j >= start_i && cell_ok[j]) begin
        found     = 1'b1;
        found_idx = IDX_W'(j);
      end
    end
  end

  // One address calculator shared by cell writes and row starts.
  always_comb begin
    case (state)
      R_LD:    begin ax = '0; ay = src_r; end
      C_LD:    begin ax = '0; ay = dst_r; end
      default: begin ax = cx_r[idx_r]; ay = cy_r[idx_r]; end
    endcase
  end

  board_cell_addr #(
    .BOARD_W  (BOARD_W),
    .COORD_W  (COORD_W),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_addr (
    .x   (ax),
    .y   (ay),
    .addr(addr_calc)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_r;
    bi_nxt    = bi_r;
    tmo_nxt   = tmo_r;
    err_nxt   = err_r;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        err_nxt = 1'b0;
        if (cmd_valid) begin
          capture = 1'b1;
          case (cmd_op_e'(cmd_op))
            OP_MOVE: begin
              if (found) begin
                state_nxt = W_LD;
                idx_nxt   = found_idx;
              end else begin
                state_nxt = FIN;
              end
            end
            OP_READ_ROW: begin
              if (src_row >= H_LIM) begin state_nxt = FIN; err_nxt = 1'b1; end
              else state_nxt = R_LD;
            end
            OP_COPY_ROW: begin
              if (src_row >= H_LIM || dst_row >= H_LIM) begin
                state_nxt = FIN;
                err_nxt   = 1'b1;
              end else begin
                state_nxt = R_LD;
              end
            end
            default: begin state_nxt = FIN; err_nxt = 1'b1; end
          endcase
        end
      end
      W_LD:  state_nxt = W_REQ;
      W_REQ: begin state_nxt = W_DRAIN; tmo_nxt = '0; end
      W_DRAIN: begin
        if (fifo.wr_buffer == '0) begin
          if (found) begin state_nxt = W_LD; idx_nxt = found_idx; end
          else state_nxt = FIN;
        end else if (tmo_r == TMO_LAST) begin
          state_nxt = FIN;
          err_nxt   = 1'b1;
        end else begin
          tmo_nxt = tmo_r + 1'b1;
        end
      end
      R_LD: begin state_nxt = R_WAIT; tmo_nxt = '0; end
      R_WAIT: begin
        if (fifo.rd_buffer >= RD_NEED) begin
          state_nxt = R_BURST;
          bi_nxt    = '0;
        end else if (tmo_r == TMO_LAST) begin
          state_nxt = FIN;
          err_nxt   = 1'b1;
        end else begin
          tmo_nxt = tmo_r + 1'b1;
        end
      end
      R_BURST: begin
        if (bi_r == BI_LAST) begin
          bi_nxt    = '0;
          state_nxt = (op_r == OP_COPY_ROW) ? C_LD : FIN;
        end else begin
          bi_nxt = bi_r + 1'b1;
        end
      end
      C_LD: state_nxt = C_REQ;
      C_REQ: begin
        if (bi_r == BI_LAST) begin state_nxt = C_DRAIN; tmo_nxt = '0; end
        else bi_nxt = bi_r + 1'b1;
      end
      C_DRAIN: begin
        if (fifo.wr_buffer == '0) begin
          state_nxt = FIN;
        end else if (tmo_r == TMO_LAST) begin
          state_nxt = FIN;
          err_nxt   = 1'b1;
        end else begin
          tmo_nxt = tmo_r + 1'b1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_r     <= OP_MOVE;
      cx_r     <= '{default: '0};
      cy_r     <= '{default: '0};
      color_r  <= '0;
      src_r    <= '0;
      dst_r    <= '0;
      idx_r    <= '0;
      bi_r     <= '0;
      tmo_r    <= '0;
      err_r    <= 1'b0;
      // NOTE: row_data is a visible output with a defined reset value, so this
      // storage is reset even though it is overwritten before any use.
      row_data <= '0;
    end else begin
      state <= state_nxt;
      idx_r <= idx_nxt;
      bi_r  <= bi_nxt;
      tmo_r <= tmo_nxt;
      err_r <= err_nxt;
      if (capture) begin
        op_r    <= cmd_op_e'(cmd_op);
        cx_r    <= in_x;
        cy_r    <= in_y;
        color_r <= piece_color;
        src_r   <= src_row;
        dst_r   <= dst_row;
      end
      // Show-ahead FIFO: the word on readdata is the one popped this cycle.
      if (state == R_BURST) row_data[bi_r] <= fifo.readdata;
    end
  end

  // Moore outputs; addresses and data are forced to zero outside their
  // strobe states so the bus is quiet whenever nothing is being transferred.
  assign cmd_ready      = (state == IDLE);
  assign done           = (state == FIN);
  assign err            = (state == FIN) && err_r;
  assign fifo.write_ld  = (state == W_LD) || (state == C_LD);
  assign fifo.write_req = (state == W_REQ) || (state == C_REQ);
  assign fifo.writeaddr = fifo.write_ld ? addr_calc : '0;
  assign fifo.writedata = (state == W_REQ) ? ((idx_r < PAINT_START) ? BG_COLOR : color_r)
                        : (state == C_REQ) ? row_data[bi_r] : '0;
  assign fifo.read_ld   = (state == R_LD);
  assign fifo.read_req  = (state == R_BURST);
  assign fifo.readaddr  = fifo.read_ld ? addr_calc : '0;

endmodule

// File: tb/tb_board_sdram_seq.sv
// Scoreboard bench for board_sdram_seq: stimulus pushes expected bus events,
// a negedge monitor pops and compares every strobe and done pulse.
module tb_board_sdram_seq;
  import board_pkg::*;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int CELLS   = 4;
  localparam int COORD_W = 7;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 25;
  localparam int TIMEOUT = 1023;

  logic                           clk = 1'b0;
  logic                           reset;
  logic                           cmd_valid, cmd_ready;
  logic [1:0]                     cmd_op;
  logic [CELLS-1:0][COORD_W-1:0]  pre_x, pre_y, post_x, post_y;
  logic [DATA_W-1:0]              piece_color;
  logic [COORD_W-1:0]             src_row, dst_row;
  logic                           done, err;
  logic [BOARD_W-1:0][DATA_W-1:0] row_data;

  always #5 clk = ~clk;

  board_sdram_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fifo ();

  board_sdram_seq #(
    .BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .CELLS(CELLS), .COORD_W(COORD_W),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(25'd0), .BG_COLOR(16'h0fff),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .pre_x(pre_x), .pre_y(pre_y), .post_x(post_x), .post_y(post_y),
    .piece_color(piece_color), .src_row(src_row), .dst_row(dst_row),
    .done(done), .err(err), .row_data(row_data), .fifo(fifo)
  );

  typedef enum logic [3:0] {K_WLD, K_WREQ, K_RLD, K_RREQ, K_DONE} kind_e;
  typedef struct {
    kind_e       kind;
    logic [27:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic ok, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  task automatic expect_ev(input kind_e k, input logic [27:0] v);
    exp_q.push_back('{kind: k, val: v});
  endtask

  task automatic observe(input kind_e k, input logic [27:0] v);
    exp_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected_%s", k.name()), 1'b0, {4'(k), v}, 32'hffff_ffff);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event_%s", e.kind.name()), (k == e.kind) && (v == e.val),
            {4'(k), v}, {4'(e.kind), e.val});
    end
  endtask

  // FIFO controller model: write side empties 2 cycles after the last push
  // (or sticks at 1 while hold_wr); read side fills to BOARD_W 5 cycles after
  // read_ld and presents rd_base + pops + 1 show-ahead.
  bit          hold_wr = 1'b0;
  logic [15:0] rd_base = '0;
  int          wr_q = 0, wr_age = 0, rd_tmr = 0, rd_q = 0, pop_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      wr_q = 0; wr_age = 0; rd_tmr = 0; rd_q = 0; pop_cnt = 0;
    end else begin
      fifo.readdata = DATA_W'(int'(rd_base) + pop_cnt + 1);
      if (fifo.write_req) begin
        wr_q++;
        wr_age = 0;
      end else if (wr_q > 0 && !hold_wr) begin
        wr_age++;
        if (wr_age >= 2) wr_q = 0;
      end
      if (fifo.read_ld) begin
        pop_cnt = 0; rd_q = 0; rd_tmr = 5;
      end else if (fifo.read_req) begin
        pop_cnt++;
        if (rd_q > 0) rd_q--;
      end else if (rd_tmr > 0) begin
        rd_tmr--;
        if (rd_tmr == 0) rd_q = BOARD_W;
      end
    end
    fifo.wr_buffer = hold_wr ? 16'd1 : 16'(wr_q);
    fifo.rd_buffer = 16'(rd_q);
  end

  // Monitor
  always @(negedge clk) begin
    int ns;
    if (!reset) begin
      ns = int'(fifo.write_ld) + int'(fifo.write_req) + int'(fifo.read_ld) + int'(fifo.read_req);
      if (ns > 0) check("strobe_exclusive", ns == 1, ns, 1);
      if (fifo.write_ld)  observe(K_WLD, 28'(fifo.writeaddr));
      if (fifo.write_req) observe(K_WREQ, 28'(fifo.writedata));
      if (fifo.read_ld)   observe(K_RLD, 28'(fifo.readaddr));
      if (fifo.read_req)  observe(K_RREQ, 28'd0);
      if (done)           observe(K_DONE, 28'(err));
      else if (err)       check("err_without_done", 1'b0, 1, 0);
    end
  end

  task automatic set_pre(input int i, input int x, input int y);
    pre_x[i] = COORD_W'(x);
    pre_y[i] = COORD_W'(y);
  endtask

  task automatic set_post(input int i, input int x, input int y);
    post_x[i] = COORD_W'(x);
    post_y[i] = COORD_W'(y);
  endtask

  // Issue the operands already on the inputs, scramble them after acceptance,
  // wait (bounded) for done, then confirm handshake return and queue drain.
  task automatic run_cmd(input string tag, output int cycles);
    check({tag, "_ready"}, cmd_ready, 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid   = 1'b0;
    cmd_op      = 2'($urandom);
    pre_x       = 28'($urandom);
    pre_y       = 28'($urandom);
    post_x      = 28'($urandom);
    post_y      = 28'($urandom);
    piece_color = 16'($urandom);
    src_row     = 7'($urandom);
    dst_row     = 7'($urandom);
    check({tag, "_ready_low"}, !cmd_ready, 32'(cmd_ready), 0);
    cycles = 1;
    while (!done && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    if (!done) begin
      check({tag, "_done_timeout"}, 1'b0, cycles, 3000);
      exp_q.delete();
    end else begin
      @(negedge clk);
      check({tag, "_ready_back"}, cmd_ready, 32'(cmd_ready), 1);
      check({tag, "_queue_empty"}, exp_q.size() == 0, exp_q.size(), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int w;
    logic [15:0] addrs [8] = '{8, 10, 28, 30, 28, 30, 48, 50};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0;
    pre_x = '0; pre_y = '0; post_x = '0; post_y = '0;
    piece_color = '0; src_row = '0; dst_row = '0;
    fifo.wr_buffer = '0; fifo.rd_buffer = '0; fifo.readdata = '0;
    repeat (3) @(negedge clk);
    check("rst_strobes", {fifo.write_ld, fifo.write_req, fifo.read_ld, fifo.read_req, done, err} == '0,
          32'({fifo.write_ld, fifo.write_req, fifo.read_ld, fifo.read_req, done, err}), 0);
    check("rst_bus", (fifo.writeaddr | fifo.readaddr) == '0 && fifo.writedata == '0,
          32'(fifo.writeaddr | fifo.readaddr), 0);
    check("rst_row_data", row_data == '0, 32'(row_data[0]), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", cmd_ready, 32'(cmd_ready), 1);

    // MOVE: erase 2x2 block, paint it one row lower in colour 0000
    cmd_op = 2'd0; piece_color = 16'h0000;
    set_pre(0, 4, 0); set_pre(1, 5, 0); set_pre(2, 4, 1); set_pre(3, 5, 1);
    set_post(0, 4, 1); set_post(1, 5, 1); set_post(2, 4, 2); set_post(3, 5, 2);
    for (int i = 0; i < 8; i++) begin
      expect_ev(K_WLD, 28'(addrs[i]));
      expect_ev(K_WREQ, (i < 4) ? 28'h0fff : 28'h0000);
    end
    expect_ev(K_DONE, 28'd0);
    run_cmd("move", cyc);
    check("move_latency", cyc == 33, cyc, 33);

    // MOVE with every pre cell off-board (y=127): only the 4 paint writes
    cmd_op = 2'd0; piece_color = 16'h0aaa;
    for (int i = 0; i < 4; i++) set_pre(i, 0, 127);
    set_post(0, 0, 0); set_post(1, 1, 0); set_post(2, 9, 19); set_post(3, 2, 5);
    expect_ev(K_WLD, 28'd0);   expect_ev(K_WREQ, 28'h0aaa);
    expect_ev(K_WLD, 28'd2);   expect_ev(K_WREQ, 28'h0aaa);
    expect_ev(K_WLD, 28'd398); expect_ev(K_WREQ, 28'h0aaa);
    expect_ev(K_WLD, 28'd104); expect_ev(K_WREQ, 28'h0aaa);
    expect_ev(K_DONE, 28'd0);
    run_cmd("move_skip_pre", cyc);

    // MOVE with all cells just off the board edges: done only
    cmd_op = 2'd0;
    for (int i = 0; i < 4; i++) begin
      set_pre(i, 10, 0);
      set_post(i, 0, 20);
    end
    expect_ev(K_DONE, 28'd0);
    run_cmd("move_all_off", cyc);
    check("move_all_off_latency", cyc == 1, cyc, 1);

    // READ_ROW 3
    rd_base = 16'h0000; cmd_op = 2'd1; src_row = 7'd3;
    expect_ev(K_RLD, 28'd60);
    for (int i = 0; i < BOARD_W; i++) expect_ev(K_RREQ, 28'd0);
    expect_ev(K_DONE, 28'd0);
    run_cmd("read_row", cyc);
    for (int i = 0; i < BOARD_W; i++)
      check($sformatf("read_row_data_%0d", i), row_data[i] == 16'(i + 1), 32'(row_data[i]), i + 1);

    // COPY_ROW 18 -> 19
    rd_base = 16'h0100; cmd_op = 2'd2; src_row = 7'd18; dst_row = 7'd19;
    expect_ev(K_RLD, 28'd360);
    for (int i = 0; i < BOARD_W; i++) expect_ev(K_RREQ, 28'd0);
    expect_ev(K_WLD, 28'd380);
    for (int i = 0; i < BOARD_W; i++) expect_ev(K_WREQ, 28'(16'h0101 + 16'(i)));
    expect_ev(K_DONE, 28'd0);
    run_cmd("copy_row", cyc);
    check("copy_row_last_word", row_data[BOARD_W-1] == 16'h010a, 32'(row_data[BOARD_W-1]), 32'h010a);

    // Rejects: READ_ROW 20, COPY_ROW into row 20
    cmd_op = 2'd1; src_row = 7'd20;
    expect_ev(K_DONE, 28'd1);
    run_cmd("read_reject", cyc);
    check("read_reject_latency", cyc == 1, cyc, 1);
    cmd_op = 2'd2; src_row = 7'd0; dst_row = 7'd20;
    expect_ev(K_DONE, 28'd1);
    run_cmd("copy_reject", cyc);
    check("copy_reject_latency", cyc == 1, cyc, 1);

    // Drain timeout: wr_buffer stuck at 1 after the first push
    hold_wr = 1'b1; cmd_op = 2'd0; piece_color = 16'h0aaa;
    for (int i = 0; i < 4; i++) begin
      set_pre(i, 0, 127);
      set_post(i, 0, 127);
    end
    set_post(0, 0, 0);
    expect_ev(K_WLD, 28'd0);
    expect_ev(K_WREQ, 28'h0aaa);
    expect_ev(K_DONE, 28'd1);
    run_cmd("timeout", cyc);
    check("timeout_latency", cyc == TIMEOUT + 3, cyc, TIMEOUT + 3);
    hold_wr = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of a READ_ROW burst
    rd_base = 16'h0000; cmd_op = 2'd1; src_row = 7'd0;
    expect_ev(K_RLD, 28'd0);
    for (int i = 0; i < BOARD_W; i++) expect_ev(K_RREQ, 28'd0);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (!fifo.read_req && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("rst_burst_reached", fifo.read_req, 32'(fifo.read_req), 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("midrst_strobes", {fifo.write_ld, fifo.write_req, fifo.read_ld, fifo.read_req, done, err} == '0,
          32'({fifo.write_ld, fifo.write_req, fifo.read_ld, fifo.read_req, done, err}), 0);
    check("midrst_bus", (fifo.writeaddr | fifo.readaddr) == '0 && fifo.writedata == '0,
          32'(fifo.writeaddr | fifo.readaddr), 0);
    check("midrst_row_data", row_data == '0, 32'(row_data[0]), 0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", cmd_ready, 32'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    check("midrst_quiet", exp_q.size() == 0, exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/board_sdram_seq.md
# board_sdram_seq

Parametrised playfield access sequencer between game logic and the SDRAM FIFO controller. It accepts one command at a time: MOVE (erase a piece's old cells, paint its new cells), READ_ROW (burst-read one board row into a register array) or COPY_ROW (read a row and rewrite it to another row, used for line-clear compaction). Board geometry, piece size and data width are generic. It adds skipping of off-board cells, an explicit command handshake and a FIFO-drain timeout.

## Interface
Parameters:
- BOARD_W, 10, cells per row
- BOARD_H, 20, rows
- CELLS, 4, cells per piece
- COORD_W, 7, coordinate width
- DATA_W, 16, SDRAM word width
- ADDR_W, 25, SDRAM byte address width
- BASE_ADDR, 0, byte address of cell (0,0)
- BG_COLOR, 16'h0fff, erase colour
- TIMEOUT, 1023, maximum drain-wait cycles

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; one clock, no other clock domain
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=MOVE, 1=READ_ROW, 2=COPY_ROW, 3=reserved
- pre_x, pre_y  in  CELLS×COORD_W  old cell positions
- post_x, post_y  in  CELLS×COORD_W  new cell positions
- piece_color  in  DATA_W  paint colour
- src_row, dst_row  in  COORD_W  row operands
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse, coincident with done, on reject or timeout
- row_data  out  BOARD_W×DATA_W  last row read
- write_ld, write_req  out  1  FIFO write-load / push strobes
- writeaddr  out  ADDR_W  FIFO write start address
- writedata  out  DATA_W  FIFO push data
- wr_buffer  in  16  write FIFO occupancy
- read_ld, read_req  out  1  FIFO read-load / pop strobes
- readaddr  out  ADDR_W  FIFO read start address
- readdata  in  DATA_W  show-ahead read data
- rd_buffer  in  16  read FIFO occupancy

## Operation
- A command is accepted on cmd_valid && cmd_ready. All operands are registered at acceptance; later input changes have no effect.
- Address of a cell: BASE_ADDR + ((y·BOARD_W + x) << 1). Computed at ADDR_W bits, with no truncation before the shift.
- MOVE: erase loop over pre cells 0..CELLS-1 writing BG_COLOR, then paint loop over post cells writing piece_color.
  - A cell with x≥BOARD_W or y≥BOARD_H is skipped and costs 0 FIFO cycles.
  - MOVE with all cells off-board completes with done only.
- READ_ROW: if src_row≥BOARD_H, reject immediately (done+err, no FIFO activity). Otherwise burst-read BOARD_W words into row_data[0..BOARD_W-1].
- COPY_ROW: a row operand ≥BOARD_H causes a reject. Otherwise perform READ_ROW(src_row), then one write_ld at the dst_row start address, then BOARD_W consecutive write_req pushes of row_data[i]. The FIFO auto-increments the address per push.
- FSM states: IDLE, W_LD, W_REQ, W_DRAIN, R_LD, R_WAIT, R_BURST, C_LD, C_REQ, C_DRAIN, FIN.
  - W_LD: write_ld=1 with writeaddr valid.
  - W_REQ: write_req=1 with writedata valid.
  - W_DRAIN: wait for wr_buffer==0 with write_req low, then go to the next cell or FIN.
  - R_LD: read_ld=1 for one cycle.
  - R_WAIT: wait for rd_buffer≥BOARD_W.
  - R_BURST: read_req high BOARD_W consecutive cycles; readdata is captured into index i in the same cycle.
  - C_LD, C_REQ, C_DRAIN: write-side equivalents for the copy.
- Timeout: counter clears on entering W_DRAIN, R_WAIT or C_DRAIN. If it reaches TIMEOUT, abort to FIN with err. Outstanding FIFO contents are left as-is.

## Timing
- Reset values: every strobe, done, err and address/data output is 0; row_data is all 0; state is IDLE; cmd_ready=1 after reset deassertion.
- Reset mid-command aborts immediately with no further strobes.
- cmd_ready falls the cycle after acceptance.
- Per in-range MOVE cell: 1 cycle W_LD + 1 cycle W_REQ + at least 1 cycle W_DRAIN. Minimum MOVE latency for 8 in-range cells is 24 cycles + FIN.
- Strobes are one-cycle pulses, never overlapping. write_ld and write_req are never high together. read_req is held exactly BOARD_W cycles.
- done and err are asserted in FIN; cmd_ready returns the following cycle.
- row_data is updated only during R_BURST and is stable at done.

## Structure
- board_pkg: cmd_op_e enum, state enum, and cell_addr() function.
- Sub-module board_cell_addr: combinational address calculator, instantiated once and muxed by a cell index.

## Test plan
- MOVE, pre=(4,0),(5,0),(4,1),(5,1), post=(4,1),(5,1),(4,2),(5,2), piece_color=16'h0000, wr_buffer emptied after 2 cycles -> 8 write_ld at addrs 8,10,28,30,28,30,48,50; data 0fff×4 then 0000×4; one done.
- MOVE with pre y=127 for all cells, post in range -> exactly 4 writes, no writes for pre cells.
- READ_ROW src_row=3, rd_buffer reaches 10 after 5 cycles, readdata=i+1 -> readaddr=60, read_req high 10 cycles, row_data={1..10}, done.
- COPY_ROW src=18, dst=19 -> read at 360, write_ld at 380, 10 pushes matching read data, done without err.
- READ_ROW src_row=20 -> done+err the cycle after acceptance, no strobes.
- wr_buffer held at 1 -> err+done after TIMEOUT cycles in W_DRAIN; assert reset mid-burst -> all outputs 0 next cycle.
